// File: rtl/jellyvl_etherneco_synctimer_slave.sv
// Sync-timer ring slave: parses 12-byte sync packets into set/adjust requests for the
// local timer and forwards every byte downstream with the node-id byte incremented.
module jellyvl_etherneco_synctimer_slave #(
    parameter int          TIMER_WIDTH  = 64,
    parameter logic [7:0]  CMD_OVERRIDE = 8'h10,
    parameter logic [7:0]  CMD_CORRECT  = 8'h11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [TIMER_WIDTH-1:0] current_time,
    input  logic                   s_last,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   m_last,
    output logic [7:0]             m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [7:0]             node_id,
    output logic [TIMER_WIDTH-1:0] set_time,
    output logic                   set_valid,
    output logic                   adjust_sign,
    output logic                   adjust_valid,
    input  logic                   adjust_ready
);

    typedef enum logic {RECV, SKIP} state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             idx_reg, idx_next;
    logic                   complete;
    logic                   accept;
    logic [7:0]             cmd_reg;
    logic [63:0]            time_reg;
    logic [7:0]             offset_lo_reg;
    logic [TIMER_WIDTH-1:0] local_cap_reg;
    logic [7:0]             node_id_reg;
    logic [TIMER_WIDTH-1:0] set_time_reg;
    logic                   set_valid_reg;
    logic                   adjust_sign_reg;
    logic                   adjust_valid_reg;
    logic [7:0]             time_byte_hit;
    logic [TIMER_WIDTH-1:0] target;
    logic [TIMER_WIDTH-1:0] diff;

    assign accept  = s_valid && s_ready;
    assign s_ready = m_ready;
    assign m_valid = s_valid;
    assign m_last  = s_last;
    // idx parks at 12 while skipping, so only a real header byte gets incremented
    assign m_data  = (idx_reg == 4'd0) ? s_data + 8'd1 : s_data;

    assign node_id      = node_id_reg;
    assign set_time     = set_time_reg;
    assign set_valid    = set_valid_reg;
    assign adjust_sign  = adjust_sign_reg;
    assign adjust_valid = adjust_valid_reg;

    // The last offset byte is still on s_data when the packet completes
    assign target = time_reg[TIMER_WIDTH-1:0] + TIMER_WIDTH'({s_data, offset_lo_reg});
    assign diff   = target - local_cap_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_time_hit
            assign time_byte_hit[gi] = accept && (state_reg == RECV) && (idx_reg == 4'(gi + 2));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RECV;
            idx_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        complete   = 1'b0;
        if (accept) begin
            case (state_reg)
                RECV: begin
                    if (s_last) begin
                        idx_next = 4'd0;
                        complete = (idx_reg == 4'd11);
                    end else if (idx_reg == 4'd11) begin
                        state_next = SKIP;
                        idx_next   = 4'd12;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
                SKIP: begin
                    if (s_last) begin
                        state_next = RECV;
                        idx_next   = 4'd0;
                    end
                end
                default: begin
                    state_next = RECV;
                    idx_next   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_reg       <= 8'd0;
            time_reg      <= 64'd0;
            offset_lo_reg <= 8'd0;
            local_cap_reg <= '0;
            node_id_reg   <= 8'd0;
        end else begin
            if (accept && state_reg == RECV) begin
                case (idx_reg)
                    4'd0: begin
                        node_id_reg   <= s_data + 8'd1;
                        local_cap_reg <= current_time;
                    end
                    4'd1:    cmd_reg       <= s_data;
                    4'd10:   offset_lo_reg <= s_data;
                    default: ;
                endcase
            end
            for (int i = 0; i < 8; i++) begin
                if (time_byte_hit[i]) begin
                    time_reg[8*i +: 8] <= s_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            set_time_reg     <= '0;
            set_valid_reg    <= 1'b0;
            adjust_sign_reg  <= 1'b0;
            adjust_valid_reg <= 1'b0;
        end else begin
            set_valid_reg <= 1'b0;
            if (complete && cmd_reg == CMD_OVERRIDE) begin
                set_time_reg     <= target;
                set_valid_reg    <= 1'b1;
                adjust_valid_reg <= 1'b0;
            end else if (complete && cmd_reg == CMD_CORRECT) begin
                // A fresh correction supersedes any pending request
                if (diff == '0) begin
                    adjust_valid_reg <= 1'b0;
                end else begin
                    adjust_valid_reg <= 1'b1;
                    adjust_sign_reg  <= diff[TIMER_WIDTH-1];
                end
            end else if (adjust_valid_reg && adjust_ready) begin
                adjust_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_slave.sv
// Directed bench for the sync-timer slave: override, correction, wrap, framing,
// backpressure and mid-packet reset.
module tb_jellyvl_etherneco_synctimer_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] current_time;
    logic        s_last, s_valid, s_ready;
    logic [7:0]  s_data;
    logic        m_last, m_valid, m_ready;
    logic [7:0]  m_data;
    logic [7:0]  node_id;
    logic [63:0] set_time;
    logic        set_valid, adjust_sign, adjust_valid, adjust_ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0] pkt [16];

    jellyvl_etherneco_synctimer_slave #(
        .TIMER_WIDTH (64),
        .CMD_OVERRIDE(8'h10),
        .CMD_CORRECT (8'h11)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .current_time(current_time),
        .s_last      (s_last),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_last      (m_last),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .node_id     (node_id),
        .set_time    (set_time),
        .set_valid   (set_valid),
        .adjust_sign (adjust_sign),
        .adjust_valid(adjust_valid),
        .adjust_ready(adjust_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    task automatic make_pkt(input logic [7:0] id, input logic [7:0] cmd,
                            input logic [63:0] t, input logic [15:0] off);
        pkt[0] = id;
        pkt[1] = cmd;
        for (int i = 0; i < 8; i++) pkt[2+i] = t[8*i +: 8];
        pkt[10] = off[7:0];
        pkt[11] = off[15:8];
        pkt[12] = 8'hAA;
        pkt[13] = 8'h55;
    endtask

    // Drives one byte, optionally stalled, and checks the forwarded copy
    task automatic send_byte(input logic [7:0] d, input logic last, input logic first, input int stall);
        logic [7:0] exp_d;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        m_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            #1 check("s_ready_stall", {63'd0, s_ready}, 64'd0);
            @(negedge clk);
        end
        m_ready = 1'b1;
        exp_d = first ? d + 8'd1 : d;
        #1;
        check("m_data", {56'd0, m_data}, {56'd0, exp_d});
        check("m_last", {63'd0, m_last}, {63'd0, last});
        @(posedge clk);
    endtask

    // Sends pkt[0..n-1] with s_last on the final byte; returns at the negedge after completion
    task automatic send_pkt(input int n, input bit stalled);
        for (int i = 0; i < n; i++)
            send_byte(pkt[i], i == n - 1, i == 0, stalled ? (i % 3) : 0);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; current_time = 64'd0; s_last = 1'b0; s_data = 8'd0;
        s_valid = 1'b0; m_ready = 1'b1; adjust_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_node_id", {56'd0, node_id}, 64'd0);
        check("rst_set_time", set_time, 64'd0);
        check("rst_set_valid", {63'd0, set_valid}, 64'd0);
        check("rst_adj_valid", {63'd0, adjust_valid}, 64'd0);
        reset = 1'b0;

        // Override
        make_pkt(8'h00, 8'h10, 64'h1000, 16'h0010);
        send_pkt(12, 1'b0);
        check("ovr_set_valid", {63'd0, set_valid}, 64'd1);
        check("ovr_set_time", set_time, 64'h1010);
        check("ovr_node_id", {56'd0, node_id}, 64'd1);
        @(negedge clk);
        check("ovr_pulse_end", {63'd0, set_valid}, 64'd0);

        // Correction, local behind
        current_time = 64'h2000;
        make_pkt(8'h04, 8'h11, 64'h2000, 16'h0010);
        send_pkt(12, 1'b0);
        check("cor_valid", {63'd0, adjust_valid}, 64'd1);
        check("cor_sign", {63'd0, adjust_sign}, 64'd0);
        check("cor_node_id", {56'd0, node_id}, 64'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("cor_hold", {63'd0, adjust_valid}, 64'd1);
        end
        adjust_ready = 1'b1;
        @(negedge clk);
        adjust_ready = 1'b0;
        check("cor_clear", {63'd0, adjust_valid}, 64'd0);

        // Correction, local ahead
        current_time = 64'h2020;
        send_pkt(12, 1'b0);
        check("cor_ahead_valid", {63'd0, adjust_valid}, 64'd1);
        check("cor_ahead_sign", {63'd0, adjust_sign}, 64'd1);
        adjust_ready = 1'b1;
        @(negedge clk);
        adjust_ready = 1'b0;

        // Correction, zero diff
        current_time = 64'h2010;
        send_pkt(12, 1'b0);
        check("cor_zero", {63'd0, adjust_valid}, 64'd0);

        // Wrap
        make_pkt(8'h01, 8'h10, 64'hFFFF_FFFF_FFFF_FFF8, 16'h0010);
        send_pkt(12, 1'b0);
        check("wrap_set_valid", {63'd0, set_valid}, 64'd1);
        check("wrap_set_time", set_time, 64'h8);

        // Short packet, then a good one
        make_pkt(8'h07, 8'h10, 64'h5555, 16'h0001);
        send_pkt(6, 1'b0);
        check("short_set", {63'd0, set_valid}, 64'd0);
        check("short_adj", {63'd0, adjust_valid}, 64'd0);
        check("short_node_id", {56'd0, node_id}, 64'h8);
        send_pkt(12, 1'b0);
        check("after_short_set", {63'd0, set_valid}, 64'd1);
        check("after_short_time", set_time, 64'h5556);

        // Over-long packet enters SKIP; bytes 12-13 forwarded unmodified
        make_pkt(8'h02, 8'h10, 64'h9000, 16'h0000);
        send_pkt(14, 1'b0);
        check("long_set", {63'd0, set_valid}, 64'd0);
        check("long_time_kept", set_time, 64'h5556);
        make_pkt(8'h02, 8'h10, 64'h3000, 16'h0002);
        send_pkt(12, 1'b0);
        check("after_long_set", {63'd0, set_valid}, 64'd1);
        check("after_long_time", set_time, 64'h3002);

        // Backpressure
        make_pkt(8'h10, 8'h10, 64'h1234_5678_9ABC_DEF0, 16'h0100);
        send_pkt(12, 1'b1);
        check("bp_set_valid", {63'd0, set_valid}, 64'd1);
        check("bp_set_time", set_time, 64'h1234_5678_9ABC_DFF0);
        check("bp_node_id", {56'd0, node_id}, 64'h11);

        // Reset at idx 6 with an adjust request pending
        current_time = 64'h2020;
        make_pkt(8'h04, 8'h11, 64'h2000, 16'h0010);
        send_pkt(12, 1'b0);
        check("pre_rst_adj", {63'd0, adjust_valid}, 64'd1);
        make_pkt(8'h20, 8'h10, 64'h4000, 16'h0004);
        for (int i = 0; i < 6; i++) send_byte(pkt[i], 1'b0, i == 0, 0);
        @(negedge clk);
        s_valid = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        check("mid_rst_node_id", {56'd0, node_id}, 64'd0);
        check("mid_rst_set_time", set_time, 64'd0);
        check("mid_rst_set_valid", {63'd0, set_valid}, 64'd0);
        check("mid_rst_adj_valid", {63'd0, adjust_valid}, 64'd0);
        check("mid_rst_adj_sign", {63'd0, adjust_sign}, 64'd0);
        send_pkt(12, 1'b0);
        check("post_rst_set", {63'd0, set_valid}, 64'd1);
        check("post_rst_time", set_time, 64'h4004);
        check("post_rst_node_id", {56'd0, node_id}, 64'h21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jellyvl_etherneco_synctimer_slave.md
Name: jellyvl_etherneco_synctimer_slave

Overview:
- Ring-node consumer of the sync-timer command stream produced by the synctimer master.
- Parses each 12-byte sync packet and drives the local timer: sets it on an override command, or issues single-step adjust requests on a correction command.
- Forwards the packet unchanged toward the next node, except that the node-id byte is incremented.

Parameters:
- TIMER_WIDTH, 64: timer bit width (at most 64; the time field carries 64 bits).
- CMD_OVERRIDE, 8'h10: command code for "set time".
- CMD_CORRECT, 8'h11: command code for "adjust time".

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- current_time  input  TIMER_WIDTH  local timer value.
- s_last  input  1  last byte of packet.
- s_data  input  8  packet byte.
- s_valid  input  1  input byte valid.
- s_ready  output  1  input byte accepted.
- m_last  output  1  forwarded last.
- m_data  output  8  forwarded byte.
- m_valid  output  1  forwarded valid.
- m_ready  input  1  downstream ready.
- node_id  output  8  own id (received id + 1).
- set_time  output  TIMER_WIDTH  time to load.
- set_valid  output  1  one-cycle load strobe.
- adjust_sign  output  1  1 = local timer ahead (retard), 0 = behind (advance).
- adjust_valid  output  1  adjust request.
- adjust_ready  input  1  timer accepts adjust.

Behaviour:
- Packet format, little-endian, byte index 0..11:
  - byte 0: node id.
  - byte 1: cmd.
  - bytes 2-9: time[63:0].
  - bytes 10-11: offset[15:0].
  - s_last is asserted on byte 11 only.
- Forwarding path is combinational:
  - s_ready = m_ready; m_valid = s_valid; m_last = s_last.
  - m_data = s_data + 1 (mod 256) when idx == 0, otherwise s_data.
- Accept = s_valid && s_ready. All parsing registers advance only on accept.
- Byte counter idx:
  - Reset value 0; increments on accept.
  - Returns to 0 on any accepted byte with s_last=1.
- States:
  - RECV: idx < 12, normal capture.
  - SKIP: entered when byte 11 is accepted without s_last. Discards all bytes until an accepted s_last, then returns to RECV with idx=0. No timer action results.
- Captures:
  - idx 0: node_id <= s_data+1 (visible the cycle after accept); local_cap <= current_time.
  - idx 1: cmd register.
  - idx 2-9: time bytes.
  - idx 10-11: offset bytes.
- Short packet (s_last before idx 11): discarded, no action; node_id still updates.
- Completion: accepted byte with idx 11 and s_last=1. Then target = time + zero-extended offset, modulo 2^TIMER_WIDTH.
  - cmd == CMD_OVERRIDE: set_time <= target; set_valid = 1 for exactly one cycle, the cycle after completion.
  - cmd == CMD_CORRECT:
    - diff = target - local_cap, TIMER_WIDTH-bit two's complement.
    - diff == 0: no request.
    - Otherwise adjust_valid <= 1 and adjust_sign <= diff[MSB] (negative means local ahead → 1).
  - Any other cmd: no action.
- Adjust handshake:
  - adjust_valid holds until a cycle with adjust_ready=1, then clears next cycle.
  - adjust_sign is stable while valid.
  - A new correction completing while a request is pending overwrites adjust_sign and keeps valid. A zero diff in that case clears the request.
- Override while an adjust is pending clears adjust_valid in the same update.
- Reset values (reset mid-packet drops the partial packet):
  - idx = 0, state = RECV.
  - set_valid = 0, adjust_valid = 0, adjust_sign = 0, set_time = 0, node_id = 0.
- m_ready=0 stalls parsing; no byte is lost or duplicated.

Test Plan:
- Override packet: id 8'h00, cmd 8'h10, time 64'h0000_0000_0000_1000, offset 16'h0010.
  - m_data byte0 = 8'h01 and node_id = 1.
  - set_valid one-cycle pulse the cycle after byte 11, with set_time = 64'h1010.
- Correction packet: cmd 8'h11, time 64'h2000, offset 16'h0010, current_time at byte 0 = 64'h2000.
  - adjust_valid=1, adjust_sign=0.
  - Hold adjust_ready=0 for 5 cycles: request stays asserted.
  - Ready=1: adjust_valid clears the next cycle.
- Correction with local_cap = 64'h2020, same packet:
  - adjust_sign=1.
  - With local_cap = 64'h2010: no adjust_valid.
- Wrap: time 64'hFFFF_FFFF_FFFF_FFF8, offset 16'h0010, override.
  - set_time = 64'h8.
- Framing:
  - s_last on byte 5: no set/adjust; the next good packet is parsed correctly.
  - 14-byte packet with s_last on byte 13: SKIP entered, no action, recovers.
- Backpressure and reset:
  - Random m_ready gaps on an override packet: m stream equals s stream with byte0+1; result identical to the no-stall case.
  - Reset asserted at idx 6: all outputs return to reset values; the following packet is parsed from byte 0.
